serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the sequential, width-generic successor to the single-bit combinational full adder, for datapaths where area matters more than latency. A start/busy/done handshake lets a controller launch an operation and collect the registered result.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only when busy=0
- mode  input  1  0 = add (a + b + cin), 1 = subtract (a - b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in for add; ignored when mode=1; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- s  output  WIDTH  result; holds its value until the next accepted start completes
- cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB

## Operation
- Three states: IDLE, SHIFT, DONE.
- Reset: the state returns to IDLE, and busy, done, s, cout, ovf, the internal operand/carry registers and the bit counter are all cleared to 0.
- IDLE, start=1: latch a into the A shift register.
  - mode=0: latch b as is; carry = cin.
  - mode=1: latch ~b; carry = 1.
  - Clear the counter and go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - Sum bit = A[0] ^ B[0] ^ carry; it is shifted into the MSB of the result register, with the result register shifting right.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right by one; the counter increments.
- SHIFT, final bit (counter = WIDTH-1):
  - Capture the carry into bit WIDTH-1 for ovf computation.
  - Load the final carry into cout.
  - Go to DONE.
- The s output updates only on entry to DONE, never with partial sums.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted with the same latching rules as IDLE, and the state goes directly to SHIFT.
  - Otherwise go to IDLE.
- start while in SHIFT is ignored. The operation in flight is unaffected and no request is queued.
- Changes on a, b, mode or cin after the start cycle have no effect on the operation in flight.
- Width rules:
  - Result is modulo 2^WIDTH.
  - cout is the (WIDTH+1)th bit.
  - ovf uses the signed interpretation of both operands (for subtract, of a and -b).

## Timing
- Start accepted at edge 0. busy=1 after edges 1..WIDTH (WIDTH cycles).
- done=1 and s/cout/ovf valid after edge WIDTH+1. Latency is WIDTH+1 cycles from start to done.
- busy=0 during the DONE cycle.
- Back-to-back: a start during DONE gives a throughput of one result per WIDTH+1 cycles.
- s, cout and ovf stay stable from done until the done of the next operation. They are not cleared on a new start.
- Reset mid-operation (any state): the next cycle shows IDLE with all outputs 0. No done pulse is generated for the aborted operation.
- Simultaneous rst and start: rst wins and start is dropped.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, s=8'h00, cout=0, ovf=0. Release with start=0 -> outputs stay 0.
- Add, WIDTH=8: a=8'h5A, b=8'h3C, cin=0, mode=0.
  - Result: s=8'h96, cout=0, ovf=1.
  - Timing: busy high for exactly 8 cycles; done pulses once, 9 cycles after start.
- Add with carry-in: a=8'hFF, b=8'h01, cin=1 -> s=8'h01, cout=1, ovf=0.
  - Then a=8'h7F, b=8'h00, cin=1 -> s=8'h80, cout=0, ovf=1.
- Subtract:
  - a=8'h10, b=8'h20, mode=1, cin=1 (ignored) -> s=8'hF0, cout=0, ovf=0.
  - a=8'h80, b=8'h01 -> s=8'h7F, cout=1, ovf=1.
- Handshake edge cases:
  - start pulsed again 3 cycles into SHIFT with different operands -> ignored; the first result is unchanged.
  - start held high through DONE -> second operation begins immediately; done pulses are WIDTH+1 cycles apart.
  - rst asserted at SHIFT cycle 4 -> busy=0 on the next cycle, no done pulse, s=0.
- Exhaustive at WIDTH=2: all 4×4 operand pairs × cin × mode compared against a reference model. s, cout and ovf must match for every case.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake and result registers that hold between operations.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cmsb_q, cmsb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic sum_bit;
  logic carry_nxt;
  logic accept;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign accept    = bus.start && (state_q != S_SHIFT);

  // Next-state, datapath and output computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = (state_q == S_SHIFT);
    done_d  = (state_q == S_DONE);

    // Results publish only while leaving DONE, so partial sums are never visible
    if (state_q == S_DONE) begin
      s_d    = sum_q;
      cout_d = carry_q;
      ovf_d  = carry_q ^ cmsb_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          carry_d = bus.mode ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table vectors, handshake corner cases,
// and an exhaustive sweep of a 2-bit instance, all through expectation queues.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  res_t q8[$];
  res_t q2[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: signed overflow from operand/result sign bits
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic mode, input logic cin);
    logic [63:0] mask, av, bp, full;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    av     = {32'd0, a} & mask;
    bp     = (mode ? ~{32'd0, b} : {32'd0, b}) & mask;
    full   = av + bp + {63'd0, (mode ? 1'b1 : cin)};
    r.s    = 32'(full & mask);
    r.cout = full[w];
    r.ovf  = (av[w-1] == bp[w-1]) && (full[w-1] != av[w-1]);
    return r;
  endfunction

  function automatic res_t mk(input logic [7:0] s, input logic c, input logic o);
    res_t r;
    r.s = 32'(s); r.cout = c; r.ovf = o;
    return r;
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic m, input logic c);
    bus8.a = a; bus8.b = b; bus8.mode = m; bus8.cin = c;
  endtask

  // Drive one start pulse; returns at the negedge after the accepting edge
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic m, input logic c);
    @(negedge clk);
    drive8(a, b, m, c);
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic step8(inout int n, inout int bn);
    @(negedge clk);
    n++;
    if (bus8.busy) bn++;
  endtask

  // Wait for done (bounded), then check timing and pop/compare the scoreboard
  task automatic finish8(input string name, input int n_in, input int bn_in);
    int n, bn;
    res_t e;
    n = n_in; bn = bn_in;
    while (n < 40 && !bus8.done) step8(n, bn);
    check({name, " latency"}, 32'(n), 32'd9);
    check({name, " busy_cycles"}, 32'(bn), 32'd8);
    if (q8.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: result with empty expectation queue", name);
    end else begin
      e = q8.pop_front();
      check({name, " s"}, 32'(bus8.s), e.s);
      check({name, " cout"}, 32'(bus8.cout), 32'(e.cout));
      check({name, " ovf"}, 32'(bus8.ovf), 32'(e.ovf));
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " busy8"}, 32'(bus8.busy), 32'd0);
    check({name, " done8"}, 32'(bus8.done), 32'd0);
    check({name, " s8"}, 32'(bus8.s), 32'd0);
    check({name, " cout8"}, 32'(bus8.cout), 32'd0);
    check({name, " ovf8"}, 32'(bus8.ovf), 32'd0);
    check({name, " busy2/done2/s2"}, 32'({bus2.busy, bus2.done, bus2.s, bus2.cout, bus2.ovf}), 32'd0);
  endtask

  task automatic no_done8(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus8.done) seen++;
    end
    check({name, " spurious_done"}, 32'(seen), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int   n, bn;
    res_t e;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset held with start asserted: start must be dropped
    rst = 1'b1;
    drive8(8'hAA, 8'h55, 1'b0, 1'b1);
    bus8.start = 1'b1;
    bus2.a = 2'd3; bus2.b = 2'd1; bus2.mode = 1'b0; bus2.cin = 1'b1; bus2.start = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("post_reset");

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      q8.push_back(mk(tbl[i].s, tbl[i].cout, tbl[i].ovf));
      launch8(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].cin);
      finish8($sformatf("vec%0d", i), 0, 0);
    end

    // Random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic       rm, rc;
      ra = 8'($urandom); rb = 8'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      q8.push_back(model(8, 32'(ra), 32'(rb), rm, rc));
      launch8(ra, rb, rm, rc);
      finish8($sformatf("rnd%0d", i), 0, 0);
    end

    // Start pulsed three cycles into SHIFT with different operands is ignored
    q8.push_back(model(8, 32'h33, 32'h44, 1'b0, 1'b0));
    launch8(8'h33, 8'h44, 1'b0, 1'b0);
    n = 0; bn = 0;
    repeat (3) step8(n, bn);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b1);
    bus8.start = 1'b1;
    step8(n, bn);
    bus8.start = 1'b0;
    finish8("start_in_shift", n, bn);
    no_done8("start_in_shift", 15);

    // Start held through DONE: second op launches immediately; inputs changed
    // after the first start must not disturb the first operation
    q8.push_back(model(8, 32'h12, 32'h34, 1'b0, 1'b1));
    q8.push_back(model(8, 32'h05, 32'h09, 1'b1, 1'b0));
    @(negedge clk);
    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    bus8.start = 1'b1;
    @(negedge clk);
    drive8(8'h05, 8'h09, 1'b1, 1'b0);
    finish8("b2b_first", 0, 0);
    bus8.start = 1'b0;
    e = model(8, 32'h12, 32'h34, 1'b0, 1'b1);
    n = 0; bn = 0;
    repeat (4) step8(n, bn);
    check("b2b s_hold", 32'(bus8.s), e.s);
    finish8("b2b_second", n, bn);

    // Reset at SHIFT cycle 4 aborts without a done pulse and clears outputs
    launch8(8'h5A, 8'h3C, 1'b0, 1'b0);
    n = 0; bn = 0;
    repeat (3) step8(n, bn);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    no_done8("mid_reset", 15);

    // Exhaustive 2-bit sweep
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int im = 0; im < 2; im++) begin
            int   k;
            res_t r;
            q2.push_back(model(2, 32'(ia), 32'(ib), 1'(im), 1'(ic)));
            @(negedge clk);
            bus2.a = 2'(ia); bus2.b = 2'(ib); bus2.cin = 1'(ic); bus2.mode = 1'(im);
            bus2.start = 1'b1;
            @(negedge clk);
            bus2.start = 1'b0;
            k = 0;
            while (k < 10 && !bus2.done) begin
              @(negedge clk);
              k++;
            end
            r = q2.pop_front();
            check($sformatf("w2 a=%0d b=%0d c=%0d m=%0d latency", ia, ib, ic, im), 32'(k), 32'd3);
            check($sformatf("w2 a=%0d b=%0d c=%0d m=%0d s", ia, ib, ic, im), 32'(bus2.s), r.s);
            check($sformatf("w2 a=%0d b=%0d c=%0d m=%0d cout", ia, ib, ic, im), 32'(bus2.cout), 32'(r.cout));
            check($sformatf("w2 a=%0d b=%0d c=%0d m=%0d ovf", ia, ib, ic, im), 32'(bus2.ovf), 32'(r.ovf));
          end

    check("queue8 drained", 32'(q8.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
